// File: rtl/load_store_unit.sv
// Load/store initiator for data_mem; misaligned accesses become byte beats when LSU_MISALIGN_SPLIT_EN is defined, else they error.
// One request in flight (req_ready only in IDLE); response N+1 cycles after accept for stores, N+2 for loads, 1 for errors.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_unsigned,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic        is_unsigned,
    output logic [2:0]  xfer_size,
    output logic [31:0] address,
    output logic [31:0] w_data,
    input  logic [31:0] r_data
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;
    state_t state_q, state_d;

    logic        write_q, uns_q, split_q, pend_q;
    logic [1:0]  last_q, beat_q, pend_idx_q, beat_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q, merged, final_rdata;
    logic        mem_write_q, mem_read_q, is_unsigned_q;
    logic [2:0]  xfer_size_q;
    logic [31:0] address_q, w_data_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        size_ok, req_mis, req_err, last_beat;

    assign size_ok   = (req_size == 3'd1) || (req_size == 3'd2) || (req_size == 3'd4);
    assign req_mis   = ((req_size == 3'd2) && req_addr[0]) ||
                       ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    assign req_err   = !size_ok;
`else
    assign req_err   = !size_ok || req_mis;
`endif
    assign last_beat = (beat_q == last_q);
    assign beat_nxt  = beat_q + 2'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_err ? S_RESP : S_ISSUE;
            S_ISSUE: if (last_beat) state_d = write_q ? S_RESP : S_DRAIN;
            S_DRAIN: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lags its beat by one cycle; pend_idx_q names the byte lane it belongs to.
    always_comb begin
        merged = rdata_q;
        if (split_q) merged[{pend_idx_q, 3'b000} +: 8] = r_data[7:0];
        else         merged = r_data;
        final_rdata = merged;
        if (split_q && (last_q == 2'd1))
            final_rdata[31:16] = uns_q ? 16'h0000 : {16{merged[15]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            uns_q         <= 1'b0;
            split_q       <= 1'b0;
            last_q        <= 2'd0;
            beat_q        <= 2'd0;
            pend_q        <= 1'b0;
            pend_idx_q    <= 2'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            xfer_size_q   <= 3'd4;
            address_q     <= '0;
            w_data_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            pend_q       <= 1'b0;
            if (pend_q) rdata_q <= merged;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    write_q <= req_write;
                    uns_q   <= req_unsigned;
                    split_q <= req_mis;
                    last_q  <= req_mis ? (req_size[2] ? 2'd3 : 2'd1) : 2'd0;
                    beat_q  <= 2'd0;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    if (req_err) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        mem_write_q   <= req_write;
                        mem_read_q    <= !req_write;
                        address_q     <= req_addr;
                        xfer_size_q   <= req_mis ? 3'd1 : req_size;
                        is_unsigned_q <= req_mis ? 1'b1 : req_unsigned;
                        w_data_q      <= req_mis ? {24'b0, req_wdata[7:0]} : req_wdata;
                    end
                end
                S_ISSUE: begin
                    if (!write_q) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= beat_q;
                    end
                    if (last_beat) begin
                        mem_write_q  <= 1'b0;
                        mem_read_q   <= 1'b0;
                        resp_valid_q <= write_q;
                    end else begin
                        beat_q    <= beat_nxt;
                        address_q <= addr_q + {30'b0, beat_nxt};
                        w_data_q  <= {24'b0, wdata_q[{beat_nxt, 3'b000} +: 8]};
                    end
                end
                S_DRAIN: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= final_rdata;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign is_unsigned = is_unsigned_q;
    assign xfer_size   = xfer_size_q;
    assign address     = address_q;
    assign w_data      = w_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model plus request-level reference, checked every cycle.
module tb_load_store_unit;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write, mem_read, is_unsigned;
    logic [2:0]  xfer_size;
    logic [31:0] address, w_data;
    logic [31:0] r_data = '0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_unsigned(req_unsigned), .req_size(req_size), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_write(mem_write), .mem_read(mem_read),
        .is_unsigned(is_unsigned), .xfer_size(xfer_size), .address(address),
        .w_data(w_data), .r_data(r_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", name, got, exp);
        end
    endtask

    // data_mem stand-in: byte array, registered read with size-based extension
    bit [7:0] emem [512];
    always @(posedge clk) begin
        logic [31:0] v;
        if (mem_write)
            for (int i = 0; i < 4; i++)
                if (i < int'(xfer_size)) emem[9'(address + 32'(i))] <= w_data[8*i +: 8];
        if (mem_read) begin
            v = '0;
            for (int i = 0; i < 4; i++)
                if (i < int'(xfer_size)) v[8*i +: 8] = emem[9'(address + 32'(i))];
            if (!is_unsigned && xfer_size != 3'd4 && v[8*int'(xfer_size)-1])
                v = v | (32'hFFFFFFFF << (8*int'(xfer_size)));
            r_data <= v;
        end
    end

    // Reference: architectural memory contents and current transaction expectations
    bit [7:0]    rmem [512];
    bit          act = 1'b0;
    int          rel = 0;
    bit          m_w, m_u, m_err, m_split;
    logic [2:0]  m_sz;
    logic [31:0] m_a, m_wd, m_rdata;
    int          m_n, m_rc;
    int          seen_rel;
    logic [31:0] seen_dat;
    logic        seen_err;

    always @(negedge clk) begin
        bit beat;
        if (act) begin
            rel++;
            beat = !m_err && (rel <= m_n);
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            chk("mem_write", {31'b0, mem_write}, {31'b0, beat && m_w});
            chk("mem_read", {31'b0, mem_read}, {31'b0, beat && !m_w});
            if (beat) begin
                chk("address", address, m_split ? m_a + 32'(rel - 1) : m_a);
                chk("xfer_size", {29'b0, xfer_size}, m_split ? 32'd1 : {29'b0, m_sz});
                chk("is_unsigned", {31'b0, is_unsigned}, m_split ? 32'd1 : {31'b0, m_u});
                if (m_w)
                    chk("w_data", w_data, m_split ? ((m_wd >> (8*(rel-1))) & 32'hFF) : m_wd);
            end
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, rel == m_rc});
            if (rel == m_rc) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, m_err});
                act = 1'b0;
            end
        end else begin
            chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
            chk("resp_valid_idle", {31'b0, resp_valid}, 32'd0);
            chk("mem_access_idle", {30'b0, mem_write, mem_read}, 32'd0);
        end
        if (resp_valid) begin
            seen_rel = rel;
            seen_dat = resp_rdata;
            seen_err = resp_err;
        end
    end

    task automatic put_bytes(input logic [31:0] a, input logic [31:0] wd, input int nb);
        for (int k = 0; k < 4; k++)
            if (k < nb) rmem[9'(a + 32'(k))] = wd[8*k +: 8];
    endtask

    task automatic do_req(input bit w, input bit u, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input int rst_at);
        bit mis;
        logic [31:0] v;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_unsigned = u;
        req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clk);
        mis   = ((sz == 3'd2) && a[0]) || ((sz == 3'd4) && (a[1:0] != 2'b00));
        m_err = !((sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4)) || (mis && !SPLIT);
        m_split = mis && !m_err;
        m_w = w; m_u = u; m_sz = sz; m_a = a; m_wd = wd;
        m_n  = m_err ? 0 : (m_split ? int'(sz) : 1);
        m_rc = m_err ? 1 : (w ? m_n + 1 : m_n + 2);
        v = '0;
        if (!m_err && !w) begin
            for (int i = 0; i < 4; i++)
                if (i < int'(sz)) v[8*i +: 8] = rmem[9'(a + 32'(i))];
            if (!u && sz != 3'd4 && v[8*int'(sz)-1]) v = v | (32'hFFFFFFFF << (8*int'(sz)));
        end
        m_rdata = v;
        seen_rel = -1; seen_dat = 'x; seen_err = 'x;
        rel = 0;
        act = 1'b1;
        for (int r = 1; r <= m_rc; r++) begin
            @(negedge clk);
            if (r == rst_at) begin
                #1 rst_n = 1'b0;
                act = 1'b0;
                req_valid = 1'b0;
                #1;
                chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
                chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
                chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
                chk("rst_address", address, 32'd0);
                chk("rst_xfer_size", {29'b0, xfer_size}, 32'd4);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                if (m_w && !m_err)
                    for (int k = 0; k < 4; k++)
                        if (m_split ? (k < r - 1) : (r > 1 && k < int'(sz)))
                            rmem[9'(a + 32'(k))] = wd[8*k +: 8];
                return;
            end
            req_valid = (r < m_rc) ? 1'($urandom % 2) : 1'b0;
            req_write = 1'($urandom); req_unsigned = 1'($urandom);
            req_size = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end
        if (!m_err && w) put_bytes(a, wd, int'(sz));
        #1;
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        int          pick;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_unsigned = 1'b0;
        req_size = 3'd0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_resp", {29'b0, resp_valid, resp_err, 1'b0}, 32'd0);
        chk("reset_rdata", resp_rdata, 32'd0);
        chk("reset_mem_ctl", {29'b0, mem_write, mem_read, is_unsigned}, 32'd0);
        chk("reset_xfer_size", {29'b0, xfer_size}, 32'd4);
        chk("reset_address", address, 32'd0);
        chk("reset_w_data", w_data, 32'd0);
        rst_n = 1'b1;

        do_req(1'b1, 1'b0, 3'd4, 32'h10, 32'hDF0D873C, 0);
        chk("lit_store_cycle", 32'(seen_rel), 32'd2);
        do_req(1'b0, 1'b0, 3'd4, 32'h10, 32'h0, 0);
        chk("lit_load_cycle", 32'(seen_rel), 32'd3);
        chk("lit_load_word", seen_dat, 32'hDF0D873C);
        chk("lit_load_err", {31'b0, seen_err}, 32'd0);

        do_req(1'b1, 1'b0, 3'd1, 32'h41, 32'h12345680, 0);
        do_req(1'b0, 1'b0, 3'd1, 32'h41, 32'h0, 0);
        chk("lit_byte_signed", seen_dat, 32'hFFFFFF80);
        do_req(1'b0, 1'b1, 3'd1, 32'h41, 32'h0, 0);
        chk("lit_byte_unsigned", seen_dat, 32'h00000080);

        do_req(1'b0, 1'b0, 3'd3, 32'h10, 32'h0, 0);
        chk("lit_size3_cycle", 32'(seen_rel), 32'd1);
        chk("lit_size3_err", {31'b0, seen_err}, 32'd1);
        chk("lit_size3_rdata", seen_dat, 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
        do_req(1'b1, 1'b0, 3'd2, 32'h21, 32'hABCD873C, 0);
        chk("lit_split_hw_store_cycle", 32'(seen_rel), 32'd3);
        do_req(1'b0, 1'b0, 3'd2, 32'h21, 32'h0, 0);
        chk("lit_split_hw_signed", seen_dat, 32'hFFFF873C);
        do_req(1'b0, 1'b1, 3'd2, 32'h21, 32'h0, 0);
        chk("lit_split_hw_unsigned", seen_dat, 32'h0000873C);
        do_req(1'b1, 1'b0, 3'd4, 32'h03, 32'h11223344, 0);
        chk("lit_split_w_store_cycle", 32'(seen_rel), 32'd5);
        do_req(1'b0, 1'b0, 3'd4, 32'h03, 32'h0, 0);
        chk("lit_split_w_cycle", 32'(seen_rel), 32'd6);
        chk("lit_split_w_data", seen_dat, 32'h11223344);
        do_req(1'b0, 1'b0, 3'd4, 32'h04, 32'h0, 0);
        chk("lit_split_w_low24", seen_dat & 32'h00FFFFFF, 32'h00112233);
        do_req(1'b1, 1'b0, 3'd4, 32'h81, 32'hAABBCCDD, 3);
        do_req(1'b0, 1'b0, 3'd4, 32'h80, 32'h0, 0);
        chk("lit_after_reset_load", seen_dat, 32'h00CCDD00);
        chk("lit_after_reset_cycle", 32'(seen_rel), 32'd3);
`else
        do_req(1'b0, 1'b0, 3'd2, 32'h21, 32'h0, 0);
        chk("lit_mis_cycle", 32'(seen_rel), 32'd1);
        chk("lit_mis_err", {31'b0, seen_err}, 32'd1);
        chk("lit_mis_rdata", seen_dat, 32'd0);
        do_req(1'b1, 1'b0, 3'd4, 32'h84, 32'h55667788, 1);
        do_req(1'b0, 1'b0, 3'd4, 32'h84, 32'h0, 0);
        chk("lit_after_reset_load", seen_dat, 32'h00000000);
        chk("lit_after_reset_cycle", 32'(seen_rel), 32'd3);
`endif

        for (int i = 0; i < 300; i++) begin
            pick = $urandom % 10;
            if (pick < 3)      sz = 3'd1;
            else if (pick < 6) sz = 3'd2;
            else if (pick < 9) sz = 3'd4;
            else begin
                sz = 3'($urandom);
                if (sz == 3'd1 || sz == 3'd2 || sz == 3'd4) sz = 3'd7;
            end
            a = ($urandom % 16 == 0) ? 32'hFFFFFFFC + ($urandom % 4) : 32'h100 + ($urandom % 64);
            do_req(1'($urandom), 1'($urandom), sz, a, $urandom, 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for `data_mem`. Accepts one load/store request at a time from the execute/memory stage and drives `data_mem`'s port (`mem_write`, `mem_read`, `is_unsigned`, `xfer_size`, `address`, `w_data`, `r_data`). Misaligned accesses, which `data_mem` cannot express, are split into byte beats. Every request gets exactly one registered response pulse, read data included.

## Interface
Parameters: none.
- `clk`  in  1  sole clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; request accepted on `req_valid && req_ready` at a rising edge
- `req_write`  in  1  1 = store, 0 = load
- `req_unsigned`  in  1  zero-extend load result (ignored for stores)
- `req_size`  in  3  bytes: 1, 2 or 4; other values are an error
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, little-endian, low bytes significant
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  load result, valid with `resp_valid`; 0 for stores and errors
- `resp_err`  out  1  valid with `resp_valid`; 1 = invalid size, or misaligned when splitting is compiled out
- `mem_write`, `mem_read`, `is_unsigned`  out  1 each  to `data_mem`
- `xfer_size`  out  3  to `data_mem`
- `address`, `w_data`  out  32 each  to `data_mem`
- `r_data`  in  32  from `data_mem`; registered read, valid the cycle after `address` is presented

## Operation
- Aligned access (size 1; size 2 with `addr[0]==0`; size 4 with `addr[1:0]==0`):
  - One beat of N=1 with native `xfer_size`, `is_unsigned=req_unsigned`, `w_data=req_wdata`.
  - Load result is `r_data` taken unchanged.
- Misaligned access (size 2 with `addr[0]==1`, size 4 with `addr[1:0]!=0`):
  - N=`req_size` byte beats (`xfer_size=1`, `is_unsigned=1`), `address=req_addr+k` for k=0..N-1.
  - Address wraps modulo 2^32.
  - Store beat k: `w_data={24'b0, req_wdata[8k+7:8k]}`.
  - Load beat k: `r_data[7:0]` lands in result bits `[8k+7:8k]`. After the last beat, if signed and N<4, bits above 8N-1 are filled with bit 8N-1; otherwise they are 0.
- Request fields are registered at acceptance. Inputs are ignored outside IDLE.
- FSM:
  - IDLE: `req_ready=1`. A valid request goes to ISSUE, or to RESP if it is an error.
  - ISSUE: one beat per cycle, beat counter 0..N-1. After the last beat, loads go to DRAIN and stores go to RESP.
  - DRAIN: capture the final read byte/word, then go to RESP.
  - RESP: `resp_valid=1` for one cycle, then IDLE.
- `mem_write` is asserted only in ISSUE for stores; `mem_read` only in ISSUE for loads.
- Outside ISSUE, `address`, `xfer_size`, `w_data` and `is_unsigned` hold their last values.
- Error response: no memory beat, `resp_err=1`, `resp_rdata=0`.

## Timing
- Reset values: `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `mem_write=0`, `mem_read=0`, `is_unsigned=0`, `xfer_size=3'd4`, `address=0`, `w_data=0`. FSM in IDLE.
- Request accepted at the edge ending cycle 0:
  - Beats occupy cycles 1..N.
  - Store `resp_valid` is in cycle N+1.
  - Load `resp_valid` is in cycle N+2; beat k data is captured at the end of cycle k+2.
  - Error `resp_valid` is in cycle 1.
- Latencies:
  - aligned store 1 beat, response cycle 2
  - aligned load response cycle 3
  - misaligned word store response cycle 5
  - misaligned word load response cycle 6
- Back-to-back: `req_ready` rises the cycle after RESP. There is no overlap between requests.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately, including `mem_write`.
  - No response is issued.
  - Already-written store beats remain written.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: misaligned accesses are split into byte beats as above.
- `LSU_MISALIGN_SPLIT_EN` undefined: a misaligned access is an error and gets a response in cycle 1 with `resp_err=1` and no memory activity. Aligned behaviour is identical in both builds.

## Test plan
- Aligned word: store `0xDF0D873C` to `0x10`, then load word from `0x10` -> store response in cycle 2; load response in cycle 3 with `0xDF0D873C`, `resp_err=0`.
- Split halfword (macro on): store halfword `0x873C` to `0x21` -> byte beats at `0x21`/`0x22`. Then:
  - signed halfword load from `0x21` -> `0xFFFF873C`
  - unsigned halfword load from `0x21` -> `0x0000873C`
- Split word (macro on): store `0x11223344` to `0x03`, then load word from `0x03` -> 4 beats at `0x03..0x06`; response in cycle 6 with `0x11223344`; a word load from `0x04` returns bits `[23:0]` = `0x112233`.
- Byte sign handling: store byte `0x80` to `0x41`, then:
  - signed byte load -> `0xFFFFFF80`
  - unsigned byte load -> `0x00000080`
- Errors: `req_size=3` -> response in cycle 1 with `resp_err=1`, `resp_rdata=0`, no `mem_write`/`mem_read`. With the macro off, a halfword load from `0x21` -> the same error response.
- Reset mid-operation: drop `rst_n` during beat 2 of a misaligned word store -> `mem_write=0` immediately, no `resp_valid`, `req_ready=1` after release. The next aligned load completes normally.
